// File: rtl/store_buffer.sv
// In-order circular store buffer between the LSU and data memory: it allocates entries, fills them,
// commits them, drains them in order and forwards store data to loads. Optional perf counters: SB_PERF_CNT_EN.
module store_buffer #(
  parameter int SB_ENTRY    = 8,
  parameter int WORD_SIZE_P = 16
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        sb_alloc_v_i,
  output logic [$clog2(SB_ENTRY)-1:0] sb_alloc_num_o,
  output logic                        sb_full_o,
  output logic [$clog2(SB_ENTRY)-1:0] sb_tail_o,
  input  logic                        lsu_sb_v_i,
  input  logic [$clog2(SB_ENTRY)-1:0] lsu_sb_num_i,
  input  logic [WORD_SIZE_P-1:0]      lsu_sb_addr_i,
  input  logic [WORD_SIZE_P-1:0]      lsu_sb_data_i,
  input  logic                        rob_commit_store_v_i,
  input  logic [WORD_SIZE_P-1:0]      exe_ld_bypass_addr_i,
  input  logic [$clog2(SB_ENTRY)-1:0] exe_ld_bypass_sb_num_i,
  output logic                        sb_ld_bypass_valid_o,
  output logic [WORD_SIZE_P-1:0]      sb_ld_bypass_value_o,
  output logic                        mem_wr_v_o,
  output logic [WORD_SIZE_P-1:0]      mem_wr_addr_o,
  output logic [WORD_SIZE_P-1:0]      mem_wr_data_o,
  input  logic                        mem_wr_ready_i,
  input  logic                        mispredict_i
`ifdef SB_PERF_CNT_EN
  ,
  output logic [31:0]                 sb_bypass_hits_o,
  output logic [31:0]                 sb_full_stalls_o,
  output logic [31:0]                 sb_flushed_o
`endif
);

  localparam int IW = $clog2(SB_ENTRY);
  localparam int PW = IW + 1;

  typedef logic [IW-1:0] idx_t;
  typedef logic [PW-1:0] ptr_t;

  ptr_t head_q, head_d, cmt_q, cmt_d, tail_q, tail_d;
  logic [SB_ENTRY-1:0]    filled_q, filled_d, committed_q, committed_d;
  logic [WORD_SIZE_P-1:0] addr_q [SB_ENTRY];
  logic [WORD_SIZE_P-1:0] data_q [SB_ENTRY];

  idx_t head_idx, cmt_idx, tail_idx, fill_off;
  ptr_t occupancy, flush_cnt;
  logic full, alloc_fire, fill_fire, commit_fire, drain_fire, mem_wr_v;
  logic bypass_hit;
  logic [WORD_SIZE_P-1:0] bypass_value;

  assign head_idx  = head_q[IW-1:0];
  assign cmt_idx   = cmt_q[IW-1:0];
  assign tail_idx  = tail_q[IW-1:0];
  assign occupancy = tail_q - head_q;
  assign full      = (occupancy == ptr_t'(SB_ENTRY));

  // Fills only land on live entries; the age offset from head decides liveness across wrap.
  assign fill_off    = lsu_sb_num_i - head_idx;
  assign alloc_fire  = sb_alloc_v_i && !full && !mispredict_i;
  assign fill_fire   = lsu_sb_v_i && !mispredict_i && ({1'b0, fill_off} < occupancy);
  assign commit_fire = rob_commit_store_v_i && (cmt_q != tail_q);
  assign mem_wr_v    = committed_q[head_idx] && (head_q != cmt_q);
  assign drain_fire  = mem_wr_v && mem_wr_ready_i;
  assign flush_cnt   = tail_q - cmt_d;

  always_comb begin
    // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned (no latch).
    head_d      = drain_fire  ? head_q + ptr_t'(1) : head_q;
    cmt_d       = commit_fire ? cmt_q + ptr_t'(1)  : cmt_q;
    tail_d      = tail_q;
    filled_d    = filled_q;
    committed_d = committed_q;

    if (alloc_fire) begin
      tail_d                = tail_q + ptr_t'(1);
      filled_d[tail_idx]    = 1'b0;
      committed_d[tail_idx] = 1'b0;
    end
    if (fill_fire)   filled_d[lsu_sb_num_i] = 1'b1;
    if (commit_fire) committed_d[cmt_idx]   = 1'b1;
    if (drain_fire) begin
      filled_d[head_idx]    = 1'b0;
      committed_d[head_idx] = 1'b0;
    end
    // Flush rewinds tail to the post-commit cmt, so a store retiring this cycle survives.
    if (mispredict_i) begin
      tail_d = cmt_d;
      for (int i = 0; i < SB_ENTRY; i++) begin
        if ({1'b0, idx_t'(idx_t'(i) - cmt_d[IW-1:0])} < flush_cnt) filled_d[i] = 1'b0;
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      head_q      <= '0;
      cmt_q       <= '0;
      tail_q      <= '0;
      filled_q    <= '0;
      committed_q <= '0;
    end else begin
      head_q      <= head_d;
      cmt_q       <= cmt_d;
      tail_q      <= tail_d;
      filled_q    <= filled_d;
      committed_q <= committed_d;
    end
  end

  // NOTE: the addr/data storage is not reset; the filled/committed bits gate every read of it.
  always_ff @(posedge clk_i) begin
    if (fill_fire) begin
      addr_q[lsu_sb_num_i] <= lsu_sb_addr_i;
      data_q[lsu_sb_num_i] <= lsu_sb_data_i;
    end
  end

  // Walk oldest to youngest inside the load's window; the last match is the youngest store.
  always_comb begin
    bypass_hit   = 1'b0;
    bypass_value = '0;
    for (int k = 0; k < SB_ENTRY; k++) begin
      if ((idx_t'(k) < idx_t'(exe_ld_bypass_sb_num_i - head_idx)) &&
          filled_q[idx_t'(head_idx + idx_t'(k))] &&
          (addr_q[idx_t'(head_idx + idx_t'(k))] == exe_ld_bypass_addr_i)) begin
        bypass_hit   = 1'b1;
        bypass_value = data_q[idx_t'(head_idx + idx_t'(k))];
      end
    end
  end

  assign sb_alloc_num_o       = tail_idx;
  assign sb_tail_o            = tail_idx;
  assign sb_full_o            = full;
  assign sb_ld_bypass_valid_o = bypass_hit;
  assign sb_ld_bypass_value_o = bypass_value;
  assign mem_wr_v_o           = mem_wr_v;
  assign mem_wr_addr_o        = mem_wr_v ? addr_q[head_idx] : '0;
  assign mem_wr_data_o        = mem_wr_v ? data_q[head_idx] : '0;

  // Retiring a store while nothing is left to commit is an ROB protocol error.
  a_commit_underflow: assert property (@(posedge clk_i) disable iff (reset_i)
    !(rob_commit_store_v_i && (cmt_q == tail_q)));

`ifdef SB_PERF_CNT_EN
  logic [31:0] hits_q, hits_d, stalls_q, stalls_d, flushed_q, flushed_d;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

  always_comb begin
    hits_d    = sat_add(hits_q, {31'd0, bypass_hit});
    stalls_d  = sat_add(stalls_q, {31'd0, sb_alloc_v_i && full});
    flushed_d = sat_add(flushed_q, mispredict_i ? 32'(flush_cnt) : 32'd0);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hits_q    <= '0;
      stalls_q  <= '0;
      flushed_q <= '0;
    end else begin
      hits_q    <= hits_d;
      stalls_q  <= stalls_d;
      flushed_q <= flushed_d;
    end
  end

  assign sb_bypass_hits_o = hits_q;
  assign sb_full_stalls_o = stalls_q;
  assign sb_flushed_o     = flushed_q;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Randomized scoreboard bench for store_buffer. A queue-based store model predicts drains and bypass
// results, and an independent monitor checks every accepted memory write.
module tb_store_buffer;
  localparam int N = 8;
  localparam int W = 16;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          sb_alloc_v_i, lsu_sb_v_i, rob_commit_store_v_i, mem_wr_ready_i, mispredict_i;
  logic [2:0]    sb_alloc_num_o, sb_tail_o, lsu_sb_num_i, exe_ld_bypass_sb_num_i;
  logic          sb_full_o, sb_ld_bypass_valid_o, mem_wr_v_o;
  logic [W-1:0]  lsu_sb_addr_i, lsu_sb_data_i, exe_ld_bypass_addr_i;
  logic [W-1:0]  sb_ld_bypass_value_o, mem_wr_addr_o, mem_wr_data_o;

  store_buffer #(.SB_ENTRY(N), .WORD_SIZE_P(W)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .sb_alloc_v_i(sb_alloc_v_i), .sb_alloc_num_o(sb_alloc_num_o),
    .sb_full_o(sb_full_o), .sb_tail_o(sb_tail_o),
    .lsu_sb_v_i(lsu_sb_v_i), .lsu_sb_num_i(lsu_sb_num_i),
    .lsu_sb_addr_i(lsu_sb_addr_i), .lsu_sb_data_i(lsu_sb_data_i),
    .rob_commit_store_v_i(rob_commit_store_v_i),
    .exe_ld_bypass_addr_i(exe_ld_bypass_addr_i), .exe_ld_bypass_sb_num_i(exe_ld_bypass_sb_num_i),
    .sb_ld_bypass_valid_o(sb_ld_bypass_valid_o), .sb_ld_bypass_value_o(sb_ld_bypass_value_o),
    .mem_wr_v_o(mem_wr_v_o), .mem_wr_addr_o(mem_wr_addr_o), .mem_wr_data_o(mem_wr_data_o),
    .mem_wr_ready_i(mem_wr_ready_i), .mispredict_i(mispredict_i)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: live stores in age order; the first ncmt of them are committed.
  typedef struct { logic [W-1:0] addr; logic [W-1:0] data; bit filled; } ent_t;
  typedef struct { logic [W-1:0] addr; logic [W-1:0] data; } wr_t;
  ent_t sb[$];
  wr_t  exp_wr[$];
  int   head_abs, ncmt;
  int   n_cmp, n_bad, n_writes;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a write is accepted at the next rising edge; sample it half a cycle early.
  always @(negedge clk_i) begin
    if (!reset_i && mem_wr_v_o && mem_wr_ready_i) begin
      n_writes++;
      if (exp_wr.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
      else begin
        wr_t e;
        e = exp_wr.pop_front();
        check("wr_addr", 32'(mem_wr_addr_o), 32'(e.addr));
        check("wr_data", 32'(mem_wr_data_o), 32'(e.data));
      end
    end
  end

  function automatic int tail_idx();
    return (head_abs + sb.size()) % N;
  endfunction

  function automatic void bypass_model(input logic [W-1:0] a, input logic [2:0] num,
                                       output bit hit, output logic [W-1:0] val);
    int len;
    len = (int'(num) - head_abs) & (N - 1);
    hit = 0;
    val = '0;
    for (int k = 0; k < len && k < sb.size(); k++)
      if (sb[k].filled && sb[k].addr == a) begin
        hit = 1;
        val = sb[k].data;
      end
  endfunction

  // Apply this cycle's inputs to the model, then advance to just after the next rising edge.
  task automatic tick();
    int  sz;
    bit  full_m, drain;
    sz     = sb.size();
    full_m = (sz == N);
    drain  = (ncmt > 0) && mem_wr_ready_i;
    if (lsu_sb_v_i && !mispredict_i) begin
      int k;
      k = (int'(lsu_sb_num_i) - head_abs) & (N - 1);
      if (k < sz) begin
        sb[k].addr   = lsu_sb_addr_i;
        sb[k].data   = lsu_sb_data_i;
        sb[k].filled = 1;
      end
    end
    if (rob_commit_store_v_i && ncmt < sz) begin
      exp_wr.push_back('{addr: sb[ncmt].addr, data: sb[ncmt].data});
      ncmt++;
    end
    if (mispredict_i) while (sb.size() > ncmt) sb.delete(sb.size() - 1);
    if (drain) begin
      sb.delete(0);
      head_abs++;
      ncmt--;
    end
    if (sb_alloc_v_i && !full_m && !mispredict_i) sb.push_back('{addr: '0, data: '0, filled: 0});
    @(posedge clk_i);
    #2;
  endtask

  task automatic idle_inputs();
    sb_alloc_v_i = 0; lsu_sb_v_i = 0; rob_commit_store_v_i = 0; mispredict_i = 0;
    lsu_sb_num_i = 0; lsu_sb_addr_i = 0; lsu_sb_data_i = 0;
    exe_ld_bypass_addr_i = 0; exe_ld_bypass_sb_num_i = 0;
  endtask

  task automatic clear_model();
    sb.delete();
    exp_wr.delete();
    head_abs = 0;
    ncmt = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    mem_wr_ready_i = 0;
    reset_i = 1;
    clear_model();
    @(posedge clk_i);
    #2 reset_i = 0;
  endtask

  task automatic fill(input int num, input logic [W-1:0] a, input logic [W-1:0] d);
    lsu_sb_v_i = 1; lsu_sb_num_i = 3'(num); lsu_sb_addr_i = a; lsu_sb_data_i = d;
    tick();
    lsu_sb_v_i = 0;
  endtask

  task automatic check_all();
    bit hit;
    logic [W-1:0] val;
    bypass_model(exe_ld_bypass_addr_i, exe_ld_bypass_sb_num_i, hit, val);
    check("full", 32'(sb_full_o), 32'(sb.size() == N));
    check("tail", 32'(sb_tail_o), 32'(tail_idx()));
    check("alloc_num", 32'(sb_alloc_num_o), 32'(tail_idx()));
    check("wr_v", 32'(mem_wr_v_o), 32'(ncmt > 0));
    if (ncmt > 0 && exp_wr.size() > 0) begin
      check("wr_addr_head", 32'(mem_wr_addr_o), 32'(exp_wr[0].addr));
      check("wr_data_head", 32'(mem_wr_data_o), 32'(exp_wr[0].data));
    end
    check("byp_valid", 32'(sb_ld_bypass_valid_o), 32'(hit));
    check("byp_value", 32'(sb_ld_bypass_value_o), 32'(val));
  endtask

  initial begin
    int w0;
    n_cmp = 0; n_bad = 0; n_writes = 0;
    do_reset();

    // Reset state
    #1;
    check("rst_full", 32'(sb_full_o), 0);
    check("rst_alloc_num", 32'(sb_alloc_num_o), 0);
    check("rst_tail", 32'(sb_tail_o), 0);
    check("rst_wr_v", 32'(mem_wr_v_o), 0);
    check("rst_wr_addr", 32'(mem_wr_addr_o), 0);
    check("rst_byp_valid", 32'(sb_ld_bypass_valid_o), 0);

    // Fill the buffer; the ninth request is refused.
    for (int i = 0; i < N; i++) begin
      sb_alloc_v_i = 1;
      #1 check("alloc_seq", 32'(sb_alloc_num_o), 32'(i));
      check("alloc_not_full", 32'(sb_full_o), 0);
      tick();
    end
    check("full_after_8", 32'(sb_full_o), 1);
    tick();
    sb_alloc_v_i = 0;
    check("tail_after_9th", 32'(sb_tail_o), 0);
    check("full_after_9th", 32'(sb_full_o), 1);

    // Bypass: youngest matching filled entry inside the window wins.
    fill(0, 16'h0040, 16'hBEEF);
    fill(1, 16'h0100, 16'h1111);
    fill(3, 16'h0100, 16'h3333);
    exe_ld_bypass_addr_i = 16'h0100;
    exe_ld_bypass_sb_num_i = 3'd4;
    #1 check("byp4_valid", 32'(sb_ld_bypass_valid_o), 1);
    check("byp4_value", 32'(sb_ld_bypass_value_o), 32'h3333);
    exe_ld_bypass_sb_num_i = 3'd2;
    #1 check("byp2_value", 32'(sb_ld_bypass_value_o), 32'h1111);
    exe_ld_bypass_sb_num_i = 3'd1;
    #1 check("byp1_valid", 32'(sb_ld_bypass_valid_o), 0);
    check("byp1_value", 32'(sb_ld_bypass_value_o), 0);

    // Commit entry 0: write visible the next cycle, head moves one cycle after that.
    rob_commit_store_v_i = 1;
    mem_wr_ready_i = 1;
    tick();
    rob_commit_store_v_i = 0;
    check("drain_v", 32'(mem_wr_v_o), 1);
    check("drain_addr", 32'(mem_wr_addr_o), 32'h0040);
    check("drain_data", 32'(mem_wr_data_o), 32'hBEEF);
    check("still_full", 32'(sb_full_o), 1);
    tick();
    check("head_advanced", 32'(sb_full_o), 0);
    check("drained_v", 32'(mem_wr_v_o), 0);

    // Mispredict with a simultaneous third commit.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      sb_alloc_v_i = 1;
      tick();
    end
    sb_alloc_v_i = 0;
    for (int i = 0; i < 5; i++) fill(i, 16'h0200 + 16'(i), 16'($urandom));
    rob_commit_store_v_i = 1;
    tick();
    tick();
    mispredict_i = 1;
    tick();
    rob_commit_store_v_i = 0;
    mispredict_i = 0;
    check("mis_tail", 32'(sb_tail_o), 3);
    fill(4, 16'h0AAA, 16'h5555);
    exe_ld_bypass_addr_i = 16'h0AAA;
    exe_ld_bypass_sb_num_i = 3'd5;
    #1 check("mis_fill_dropped", 32'(sb_ld_bypass_valid_o), 0);
    exe_ld_bypass_addr_i = 16'h0203;
    #1 check("mis_flushed_miss", 32'(sb_ld_bypass_valid_o), 0);
    exe_ld_bypass_addr_i = 16'h0202;
    exe_ld_bypass_sb_num_i = 3'd3;
    #1 check("mis_kept_hit", 32'(sb_ld_bypass_valid_o), 1);
    w0 = n_writes;
    mem_wr_ready_i = 1;
    repeat (4) tick();
    check("mis_drain_count", 32'(n_writes - w0), 3);
    check("mis_drain_empty", 32'(exp_wr.size()), 0);

    // Back-pressure: valid and payload hold, then two back-to-back writes.
    do_reset();
    sb_alloc_v_i = 1;
    tick();
    tick();
    sb_alloc_v_i = 0;
    fill(0, 16'h1234, 16'hA5A5);
    fill(1, 16'h5678, 16'h5A5A);
    rob_commit_store_v_i = 1;
    tick();
    tick();
    rob_commit_store_v_i = 0;
    for (int i = 0; i < 4; i++) begin
      check("hold_v", 32'(mem_wr_v_o), 1);
      check("hold_addr", 32'(mem_wr_addr_o), 32'h1234);
      check("hold_data", 32'(mem_wr_data_o), 32'hA5A5);
      tick();
    end
    w0 = n_writes;
    mem_wr_ready_i = 1;
    tick();
    check("b2b_second_v", 32'(mem_wr_v_o), 1);
    tick();
    check("b2b_count", 32'(n_writes - w0), 2);
    check("b2b_idle", 32'(mem_wr_v_o), 0);

    // Asynchronous reset while a drain is pending.
    do_reset();
    sb_alloc_v_i = 1;
    tick();
    sb_alloc_v_i = 0;
    fill(0, 16'h0777, 16'h0888);
    rob_commit_store_v_i = 1;
    mem_wr_ready_i = 1;
    tick();
    rob_commit_store_v_i = 0;
    #1 reset_i = 1;
    clear_model();
    #1;
    check("arst_wr_v", 32'(mem_wr_v_o), 0);
    check("arst_wr_addr", 32'(mem_wr_addr_o), 0);
    check("arst_wr_data", 32'(mem_wr_data_o), 0);
    check("arst_full", 32'(sb_full_o), 0);
    check("arst_tail", 32'(sb_tail_o), 0);
    @(negedge clk_i);
    #1 reset_i = 0;
    @(posedge clk_i);
    #2 sb_alloc_v_i = 1;
    #1 check("arst_alloc_idx", 32'(sb_alloc_num_o), 0);
    tick();
    sb_alloc_v_i = 0;

    // Randomized traffic against the queue model.
    for (int c = 0; c < 600; c++) begin
      int sz;
      sz = sb.size();
      sb_alloc_v_i = ($urandom_range(0, 2) != 0);
      mem_wr_ready_i = ($urandom_range(0, 3) != 0);
      mispredict_i = ($urandom_range(0, 15) == 0);
      lsu_sb_v_i = 0;
      if ($urandom_range(0, 1) == 1) begin
        if (sz > ncmt && $urandom_range(0, 3) != 0) begin
          lsu_sb_v_i = 1;
          lsu_sb_num_i = 3'((head_abs + $urandom_range(ncmt, sz - 1)) % N);
        end else if (sz < N) begin
          lsu_sb_v_i = 1;
          lsu_sb_num_i = 3'((head_abs + $urandom_range(sz, N - 1)) % N);
        end
        lsu_sb_addr_i = 16'h0010 + 16'($urandom_range(0, 3));
        lsu_sb_data_i = 16'($urandom);
      end
      rob_commit_store_v_i = (ncmt < sz) && sb[ncmt].filled && ($urandom_range(0, 1) == 1);
      exe_ld_bypass_addr_i = 16'h0010 + 16'($urandom_range(0, 3));
      exe_ld_bypass_sb_num_i = 3'($urandom_range(0, N - 1));
      #1 check_all();
      tick();
    end

    // Retire everything still committed and confirm the scoreboard empties.
    idle_inputs();
    mem_wr_ready_i = 1;
    repeat (12) tick();
    check("final_scoreboard_empty", 32'(exp_wr.size()), 0);
    check("final_wr_v", 32'(mem_wr_v_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- In-order circular buffer of speculative stores, directly downstream of the execute stage's LSU store output.
- Entries are allocated at dispatch and filled with address/data when the LSU executes the store.
- Entries are marked committed when the ROB retires the store, then drained to data memory in order.
- Supplies combinational store-to-load bypass to execute, and discards uncommitted entries on misprediction.

Parameters:
SB_ENTRY, 8, number of entries (power of two, >=2)
WORD_SIZE_P, 16, address and data width in bits

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous active-high reset
sb_alloc_v_i  in  1  dispatch requests one entry
sb_alloc_num_o  out  $clog2(SB_ENTRY)  index granted (current tail)
sb_full_o  out  1  no free entry; allocation refused
sb_tail_o  out  $clog2(SB_ENTRY)  current tail; dispatch tags loads with it
lsu_sb_v_i  in  1  LSU fill valid
lsu_sb_num_i  in  $clog2(SB_ENTRY)  entry being filled
lsu_sb_addr_i  in  WORD_SIZE_P  store address
lsu_sb_data_i  in  WORD_SIZE_P  store data
rob_commit_store_v_i  in  1  ROB retires the oldest uncommitted store
exe_ld_bypass_addr_i  in  WORD_SIZE_P  load address
exe_ld_bypass_sb_num_i  in  $clog2(SB_ENTRY)  tail captured at load dispatch; only entries older than this are searched
sb_ld_bypass_valid_o  out  1  bypass hit
sb_ld_bypass_value_o  out  WORD_SIZE_P  forwarded data
mem_wr_v_o  out  1  drain write request
mem_wr_addr_o  out  WORD_SIZE_P  drain address
mem_wr_data_o  out  WORD_SIZE_P  drain data
mem_wr_ready_i  in  1  memory accepts the write this cycle
mispredict_i  in  1  flush all uncommitted entries

Behaviour:
- State:
  - Three pointers, each $clog2(SB_ENTRY)+1 bits (extra wrap bit): head (oldest), cmt (next to commit), tail (next free).
  - Per-entry bits: filled, committed, addr, data.
  - Invariant: head <= cmt <= tail in circular order.
- Reset (async): all pointers 0; all filled/committed bits 0; all outputs 0 except sb_alloc_num_o=0, sb_tail_o=0.
- Full: sb_full_o = (tail - head == SB_ENTRY), registered-state only.
  - An alloc while full is ignored, even if a drain occurs in the same cycle.
- Allocate: sb_alloc_v_i && !sb_full_o && !mispredict_i.
  - Entry[tail] filled=0, committed=0; tail++ next cycle.
  - sb_alloc_num_o = tail (combinational, pre-increment).
- Fill: lsu_sb_v_i writes addr/data and sets filled for entry lsu_sb_num_i.
  - The write only takes effect if the entry lies in [head, tail).
  - A fill arriving with mispredict_i, or to a flushed entry, is dropped.
- Commit: rob_commit_store_v_i sets committed on entry[cmt]; cmt++.
  - The ROB only commits filled stores.
  - A commit with cmt == tail is a protocol error: flag it with an assertion; the pointer must not move.
- Mispredict: next-cycle tail = cmt, computed after any same-cycle commit, so the committing store survives.
  - filled bits of discarded entries are cleared.
  - Committed entries keep draining normally.
- Drain:
  - mem_wr_v_o = entry[head].committed && head != cmt, registered.
  - mem_wr_addr_o/data_o come from entry[head].
  - On mem_wr_v_o && mem_wr_ready_i: clear committed, head++.
  - Minimum latency: commit in cycle N -> mem_wr_v_o in N+1.
  - Back-to-back drains at 1 per cycle when ready stays high.
  - mem_wr_v_o holds with stable addr/data until ready.
- Bypass (combinational, same cycle):
  - Search window: entries from head up to exe_ld_bypass_sb_num_i-1, covering both committed and uncommitted entries.
  - Select the youngest entry with filled=1 and addr == exe_ld_bypass_addr_i.
  - On a hit: valid=1, value = its data. Otherwise valid=0, value=0.
  - Empty window (sb_num == head index) -> no hit.
  - Unfilled older entries are not considered. Issue does not send a load to execute until all older stores have filled.
- Wrap-around:
  - Pointer index = low bits; the wrap bit distinguishes full from empty.
  - Window age comparisons use (idx - head) mod SB_ENTRY.
- Reset mid-operation: all entries discarded, including committed-not-drained ones.

Optional Feature:
- Macro SB_PERF_CNT_EN.
- When defined, three extra outputs are present:
  - sb_bypass_hits_o (32): counts cycles with sb_ld_bypass_valid_o=1.
  - sb_full_stalls_o (32): counts cycles with sb_alloc_v_i && sb_full_o.
  - sb_flushed_o (32): counts entries discarded by mispredict.
- All counters reset to 0 asynchronously and saturate at all-ones.
- When undefined: the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Alloc 8 entries with no drain -> sb_alloc_num_o 0..7, sb_full_o=1 after the 8th. A 9th alloc is ignored; tail stays at wrap=1,idx=0.
- Fill entry 0 (addr 0x0040, data 0xBEEF), commit, ready=1 -> mem_wr_v_o=1 the next cycle with 0x0040/0xBEEF; head advances 1 cycle later.
- Fill entries 1 and 3 both at addr 0x0100 (data 0x1111, 0x3333). Load at 0x0100:
  - sb_num=4 -> hit 0x3333.
  - sb_num=2 -> hit 0x1111.
  - sb_num=1 -> no hit.
- Alloc 5, commit 2, assert mispredict with a simultaneous third commit -> tail=cmt=3; entries 3,4 discarded; a later fill to entry 4 is ignored; entries 0-2 drain.
- Hold mem_wr_ready_i=0 for 4 cycles with 2 committed entries -> mem_wr_v_o stays high with stable addr/data. Raise ready -> two writes on consecutive cycles.
- Assert reset_i mid-drain, asynchronously between clock edges -> all outputs 0 immediately, sb_full_o=0; the next alloc returns index 0.
